uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter BURST_MAX, default 4, SHALL set the maximum number of bytes accepted per grant (range 1-15).
REQ-003 clk_i  in  1  system clock; all state updates occur on its rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 ch0_valid_i / ch1_valid_i  in  1  requester byte valid, held until accepted.
REQ-006 ch0_data_i / ch1_data_i  in  8  requester byte.
REQ-007 ch0_ready_o / ch1_ready_o  out  1  byte accepted this cycle when valid is also high.
REQ-008 cfg_req_i  in  1  level request to send a configuration request, held until cfg_ack_o.
REQ-009 cfg_ack_o  out  1  one-cycle pulse: configuration request completed.
REQ-010 data_tx_o  out  8  byte to transmitter FIFO; tx_fifo_write_o  out  1  FIFO write strobe.
REQ-011 tx_fifo_full_i / tx_fifo_empty_i  in  1  transmitter FIFO status.
REQ-012 tx_done_i / req_done_i  in  1  transmitter frame-done and config-done pulses.
REQ-013 enable_o  out  1  transmitter enable; config_req_mst_o  out  1  config request to transmitter.
REQ-014 grant_o  out  2  one-hot current data grant (00 = none).

Function
REQ-015 The FSM SHALL have states IDLE, GRANT, DRAIN, CFG.
REQ-016 IDLE: if cfg_req_i is high, go to DRAIN; else if any chN_valid_i is high, go to GRANT, granting the round-robin winner; else stay.
REQ-017 cfg_req_i and a valid request in the same IDLE cycle SHALL go to DRAIN (configuration wins).
REQ-018 Round-robin: with both valid, the channel not granted last SHALL win; with one valid, that channel wins.
REQ-019 GRANT: chN_ready_o = grant_o[N] & !tx_fifo_full_i; all other ready outputs are 0.
REQ-020 tx_fifo_write_o = (granted valid) & (granted ready) combinationally; data_tx_o = granted channel data; zero added latency.
REQ-021 burst_cnt SHALL clear on entry to GRANT and increment per write.
REQ-022 GRANT exit to IDLE SHALL occur on the cycle after the write that makes burst_cnt == BURST_MAX, or on any cycle the granted valid is low; grant_o clears and last-grant updates on exit.
REQ-023 GRANT with cfg_req_i high SHALL accept no further bytes (ready forced 0) and go to DRAIN next cycle.
REQ-024 tx_fifo_full_i high SHALL hold ready low without leaving GRANT and without counting toward burst.
REQ-025 busy register: set on tx_fifo_write_o; cleared on tx_done_i & tx_fifo_empty_i; set wins if both occur in the same cycle.
REQ-026 DRAIN: ready outputs 0, enable_o 1; go to CFG when busy == 0 and tx_fifo_empty_i == 1.
REQ-027 CFG: config_req_mst_o = 1 and enable_o = 0; on req_done_i, pulse cfg_ack_o that same cycle and go to IDLE, so config_req_mst_o is low on the next cycle.
REQ-028 enable_o SHALL be 1 in IDLE, GRANT and DRAIN.
REQ-029 grant_o SHALL be 00 outside GRANT.

Reset
REQ-030 While rst_i is high: state IDLE, grant_o 00, last-grant = ch1 (ch0 wins first), busy 0, burst_cnt 0.
REQ-031 While rst_i is high, all ready, tx_fifo_write_o, cfg_ack_o and config_req_mst_o outputs SHALL be 0, and enable_o SHALL be 0.
REQ-032 Reset asserted mid-GRANT or mid-CFG SHALL drop all strobes immediately, with no partial byte write.

Verification
REQ-033 Both channels continuously valid, BURST_MAX = 4 -> 4 writes from ch0 (0xA0-0xA3), then 1 IDLE cycle, then 4 writes from ch1, alternating thereafter.
REQ-034 tx_fifo_full_i high for 3 cycles mid-burst -> no writes during those cycles, burst resumes, and the total is still 4 bytes.
REQ-035 cfg_req_i during GRANT after 2 bytes -> no further writes; DRAIN is held until tx_done_i with FIFO empty; then config_req_mst_o is high until req_done_i, cfg_ack_o pulses for 1 cycle, and config_req_mst_o is low on the next cycle.
REQ-036 cfg_req_i and ch0_valid_i rise together in IDLE with busy 0 and FIFO empty -> DRAIN then CFG after 1 cycle; no data write occurs before cfg_ack_o.
REQ-037 ch1 valid drops after 1 byte -> GRANT exits the next cycle and grant_o returns to 00.
REQ-038 rst_i pulsed mid-CFG -> config_req_mst_o is 0 immediately, state is IDLE, and ch0 wins the next arbitration.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter feeding a UART transmitter FIFO,
// with a drain-then-configure handshake that takes priority over data traffic.
module uart_tx_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ch0_valid_i,
    input  logic [7:0] ch0_data_i,
    output logic       ch0_ready_o,
    input  logic       ch1_valid_i,
    input  logic [7:0] ch1_data_i,
    output logic       ch1_ready_o,
    input  logic       cfg_req_i,
    output logic       cfg_ack_o,
    output logic [7:0] data_tx_o,
    output logic       tx_fifo_write_o,
    input  logic       tx_fifo_full_i,
    input  logic       tx_fifo_empty_i,
    input  logic       tx_done_i,
    input  logic       req_done_i,
    output logic       enable_o,
    output logic       config_req_mst_o,
    output logic [1:0] grant_o
);
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN, CFG} state_t;

    state_t      state, state_nxt;
    logic [1:0]  grant, grant_nxt;
    logic        last, last_nxt;
    logic        busy;
    logic [3:0]  burst_cnt, burst_cnt_nxt;
    logic [1:0]  valid, ready;
    logic        write, gvalid, pick1, last_beat;

    assign valid     = {ch1_valid_i, ch0_valid_i};
    // last == 1 means ch1 held the most recent grant, so ch0 wins a tie
    assign pick1     = ch1_valid_i & (!ch0_valid_i | !last);
    assign ready     = (state == GRANT && !tx_fifo_full_i && !cfg_req_i) ? grant : 2'b00;
    assign write     = |(ready & valid);
    assign gvalid    = |(grant & valid);
    assign last_beat = burst_cnt == 4'(BURST_MAX - 1);

    assign ch0_ready_o     = ready[0];
    assign ch1_ready_o     = ready[1];
    assign tx_fifo_write_o = write;
    assign data_tx_o       = grant[1] ? ch1_data_i : ch0_data_i;
    assign grant_o         = grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            grant     <= 2'b00;
            last      <= 1'b1;
            busy      <= 1'b0;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_cnt_nxt;
            busy      <= write ? 1'b1 : (tx_done_i && tx_fifo_empty_i) ? 1'b0 : busy;
        end
    end

    always_comb begin
        state_nxt        = state;
        grant_nxt        = grant;
        last_nxt         = last;
        burst_cnt_nxt    = burst_cnt;
        cfg_ack_o        = 1'b0;
        config_req_mst_o = 1'b0;
        enable_o         = !rst_i;
        case (state)
            IDLE: begin
                if (cfg_req_i) begin
                    state_nxt = DRAIN;
                end else if (|valid) begin
                    state_nxt     = GRANT;
                    grant_nxt     = pick1 ? 2'b10 : 2'b01;
                    burst_cnt_nxt = 4'd0;
                end
            end
            GRANT: begin
                burst_cnt_nxt = write ? burst_cnt + 4'd1 : burst_cnt;
                // the final beat of a burst leaves on the same edge that counts it
                if (cfg_req_i || !gvalid || (write && last_beat)) begin
                    state_nxt = cfg_req_i ? DRAIN : IDLE;
                    grant_nxt = 2'b00;
                    last_nxt  = grant[1];
                end
            end
            DRAIN: begin
                state_nxt = (!busy && tx_fifo_empty_i) ? CFG : DRAIN;
            end
            CFG: begin
                config_req_mst_o = 1'b1;
                enable_o         = 1'b0;
                cfg_ack_o        = req_done_i;
                state_nxt        = req_done_i ? IDLE : CFG;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scenario tasks plus randomized traffic checked against a
// queue-level model of round-robin bursts.
module tb_uart_tx_arbiter;
    localparam int BM = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       ch0_valid_i, ch1_valid_i, ch0_ready_o, ch1_ready_o;
    logic [7:0] ch0_data_i, ch1_data_i, data_tx_o;
    logic       cfg_req_i = 1'b0, cfg_ack_o, tx_fifo_write_o;
    logic       tx_fifo_full_i = 1'b0, tx_fifo_empty_i = 1'b1;
    logic       tx_done_i = 1'b0, req_done_i = 1'b0;
    logic       enable_o, config_req_mst_o;
    logic [1:0] grant_o;

    int total = 0, passed = 0, wr_count = 0;
    logic [7:0] q0[$], q1[$];
    logic       s_wr, s_cm, s_ack, s_en;
    logic [7:0] s_data;
    logic [1:0] s_grant, s_rdy;

    uart_tx_arbiter #(.BURST_MAX(BM)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ch0_valid_i(ch0_valid_i), .ch0_data_i(ch0_data_i), .ch0_ready_o(ch0_ready_o),
        .ch1_valid_i(ch1_valid_i), .ch1_data_i(ch1_data_i), .ch1_ready_o(ch1_ready_o),
        .cfg_req_i(cfg_req_i), .cfg_ack_o(cfg_ack_o),
        .data_tx_o(data_tx_o), .tx_fifo_write_o(tx_fifo_write_o),
        .tx_fifo_full_i(tx_fifo_full_i), .tx_fifo_empty_i(tx_fifo_empty_i),
        .tx_done_i(tx_done_i), .req_done_i(req_done_i),
        .enable_o(enable_o), .config_req_mst_o(config_req_mst_o), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d passed=%0d", total, passed);
        $fatal(1);
    end

    task automatic drive();
        ch0_valid_i = q0.size() != 0;
        ch1_valid_i = q1.size() != 0;
        ch0_data_i  = 8'h00;
        ch1_data_i  = 8'h00;
        if (q0.size() != 0) ch0_data_i = q0[0];
        if (q1.size() != 0) ch1_data_i = q1[0];
    endtask

    // samples one cycle at the falling edge, then retires accepted bytes after the rising edge
    task automatic tick();
        logic a0, a1;
        @(negedge clk_i);
        a0      = ch0_valid_i & ch0_ready_o;
        a1      = ch1_valid_i & ch1_ready_o;
        s_wr    = tx_fifo_write_o;
        s_data  = data_tx_o;
        s_grant = grant_o;
        s_rdy   = {ch1_ready_o, ch0_ready_o};
        s_cm    = config_req_mst_o;
        s_ack   = cfg_ack_o;
        s_en    = enable_o;
        if (s_wr) wr_count++;
        @(posedge clk_i);
        #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cfg_req_i = 1'b0; tx_fifo_full_i = 1'b0; tx_fifo_empty_i = 1'b1;
        tx_done_i = 1'b0; req_done_i = 1'b0;
        q0.delete(); q1.delete();
        drive();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        wr_count = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        q0.push_back(8'h55); q1.push_back(8'hAA);
        cfg_req_i = 1'b1; req_done_i = 1'b1;
        drive();
        @(negedge clk_i);
        total++; if ({ch1_ready_o, ch0_ready_o, tx_fifo_write_o} !== 3'b000) $display("FAIL reset_strobes got=%b exp=000", {ch1_ready_o, ch0_ready_o, tx_fifo_write_o}); else passed++;
        total++; if (grant_o !== 2'b00) $display("FAIL reset_grant got=%b exp=00", grant_o); else passed++;
        total++; if ({cfg_ack_o, config_req_mst_o} !== 2'b00) $display("FAIL reset_cfg got=%b exp=00", {cfg_ack_o, config_req_mst_o}); else passed++;
        total++; if (enable_o !== 1'b0) $display("FAIL reset_enable got=%b exp=0", enable_o); else passed++;
        do_reset();
        tick();
        total++; if (s_en !== 1'b1) $display("FAIL idle_enable got=%b exp=1", s_en); else passed++;
        total++; if (s_grant !== 2'b00) $display("FAIL idle_grant got=%b exp=00", s_grant); else passed++;
    endtask

    task automatic test_burst_alternate();
        logic [7:0] e0[$], e1[$], d[$];
        logic [1:0] g[$];
        int t[$];
        int ch, idx;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(8'(8'hA0 + i));
            q1.push_back(8'($urandom));
        end
        e0 = q0; e1 = q1;
        drive();
        for (int c = 0; c < 60 && t.size() < 16; c++) begin
            tick();
            if (s_wr) begin t.push_back(c); d.push_back(s_data); g.push_back(s_grant); end
        end
        total++; if (t.size() !== 16) $display("FAIL alt_count got=%0d exp=16", t.size()); else passed++;
        for (int k = 0; k < t.size(); k++) begin
            ch  = (k / 4) % 2;
            idx = (k / 8) * 4 + k % 4;
            total++; if (g[k] !== (ch ? 2'b10 : 2'b01)) $display("FAIL alt_grant[%0d] got=%b exp=%b", k, g[k], ch ? 2'b10 : 2'b01); else passed++;
            total++; if (d[k] !== (ch ? e1[idx] : e0[idx])) $display("FAIL alt_data[%0d] got=%h exp=%h", k, d[k], ch ? e1[idx] : e0[idx]); else passed++;
            total++; if (t[k] - t[0] !== (k / 4) * 5 + k % 4) $display("FAIL alt_time[%0d] got=%0d exp=%0d", k, t[k] - t[0], (k / 4) * 5 + k % 4); else passed++;
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] e0[$];
        int n = 0;
        do_reset();
        repeat (6) q0.push_back(8'($urandom));
        e0 = q0;
        drive();
        for (int c = 0; c < 20 && n < 2; c++) begin
            tick();
            if (s_wr) begin
                total++; if (s_data !== e0[n]) $display("FAIL full_data[%0d] got=%h exp=%h", n, s_data, e0[n]); else passed++;
                n++;
            end
        end
        tx_fifo_full_i = 1'b1;
        repeat (3) begin
            tick();
            total++; if (s_wr !== 1'b0) $display("FAIL full_nowrite got=%b exp=0", s_wr); else passed++;
            total++; if (s_grant !== 2'b01) $display("FAIL full_hold_grant got=%b exp=01", s_grant); else passed++;
        end
        tx_fifo_full_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (s_wr) begin
                total++; if (n >= 6 || s_data !== e0[n]) $display("FAIL full_data[%0d] got=%h", n, s_data); else passed++;
                n++;
            end
            if (s_grant === 2'b00) break;
        end
        total++; if (n !== BM) $display("FAIL full_burst_len got=%0d exp=%0d", n, BM); else passed++;
    endtask

    task automatic test_random_traffic();
        logic [7:0] m0[$], m1[$], ed[$], gd[$];
        logic [1:0] eg[$], gg[$];
        int n0, n1, take;
        logic last, ch;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            n0 = $urandom_range(0, 10);
            n1 = $urandom_range(1, 10);
            repeat (n0) q0.push_back(8'($urandom));
            repeat (n1) q1.push_back(8'($urandom));
            m0 = q0; m1 = q1;
            ed.delete(); eg.delete(); gd.delete(); gg.delete();
            last = 1'b1;
            while (m0.size() != 0 || m1.size() != 0) begin
                ch = (m0.size() != 0 && m1.size() != 0) ? !last : (m1.size() != 0);
                take = ch ? m1.size() : m0.size();
                if (take > BM) take = BM;
                repeat (take) begin
                    ed.push_back(ch ? m1.pop_front() : m0.pop_front());
                    eg.push_back(ch ? 2'b10 : 2'b01);
                end
                last = ch;
            end
            drive();
            for (int c = 0; c < 300 && gd.size() < ed.size() + 1; c++) begin
                tx_fifo_full_i = $urandom_range(0, 3) == 0;
                tick();
                if (s_wr) begin gd.push_back(s_data); gg.push_back(s_grant); end
                if (gd.size() == ed.size() && c > 250) break;
            end
            tx_fifo_full_i = 1'b0;
            repeat (4) begin
                tick();
                if (s_wr) begin gd.push_back(s_data); gg.push_back(s_grant); end
            end
            total++; if (gd.size() !== ed.size()) $display("FAIL rand%0d_count got=%0d exp=%0d", r, gd.size(), ed.size()); else passed++;
            for (int k = 0; k < ed.size() && k < gd.size(); k++) begin
                total++; if (gd[k] !== ed[k] || gg[k] !== eg[k]) $display("FAIL rand%0d_beat[%0d] got=%h/%b exp=%h/%b", r, k, gd[k], gg[k], ed[k], eg[k]); else passed++;
            end
        end
    endtask

    task automatic test_cfg_mid_grant();
        logic found = 1'b0;
        do_reset();
        tx_fifo_empty_i = 1'b0;
        repeat (6) q0.push_back(8'($urandom));
        drive();
        for (int c = 0; c < 20 && wr_count < 2; c++) tick();
        total++; if (wr_count !== 2) $display("FAIL cfg_pre_writes got=%0d exp=2", wr_count); else passed++;
        cfg_req_i = 1'b1;
        tick();
        total++; if ({s_rdy, s_wr} !== 3'b000) $display("FAIL cfg_block got=%b exp=000", {s_rdy, s_wr}); else passed++;
        repeat (4) begin
            tick();
            total++; if ({s_wr, s_cm, s_en, s_grant} !== 5'b00100) $display("FAIL drain_hold got=%b exp=00100", {s_wr, s_cm, s_en, s_grant}); else passed++;
        end
        tx_done_i = 1'b1; tx_fifo_empty_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            found = s_cm;
        end
        total++; if (found !== 1'b1) $display("FAIL cfg_enter got=%b exp=1", found); else passed++;
        repeat (3) begin
            tick();
            total++; if ({s_cm, s_en, s_ack} !== 3'b100) $display("FAIL cfg_hold got=%b exp=100", {s_cm, s_en, s_ack}); else passed++;
        end
        req_done_i = 1'b1;
        tick();
        req_done_i = 1'b0; cfg_req_i = 1'b0;
        total++; if (s_ack !== 1'b1) $display("FAIL cfg_ack got=%b exp=1", s_ack); else passed++;
        total++; if (wr_count !== 2) $display("FAIL cfg_no_write got=%0d exp=2", wr_count); else passed++;
        tick();
        total++; if ({s_cm, s_ack} !== 2'b00) $display("FAIL cfg_release got=%b exp=00", {s_cm, s_ack}); else passed++;
    endtask

    task automatic test_cfg_wins();
        do_reset();
        cfg_req_i = 1'b1;
        q0.push_back(8'h77);
        drive();
        tick();
        total++; if ({s_wr, s_rdy} !== 3'b000) $display("FAIL win_idle got=%b exp=000", {s_wr, s_rdy}); else passed++;
        tick();
        total++; if ({s_cm, s_en, s_grant} !== 4'b0100) $display("FAIL win_drain got=%b exp=0100", {s_cm, s_en, s_grant}); else passed++;
        tick();
        total++; if (s_cm !== 1'b1) $display("FAIL win_cfg got=%b exp=1", s_cm); else passed++;
        req_done_i = 1'b1;
        tick();
        req_done_i = 1'b0; cfg_req_i = 1'b0;
        total++; if (s_ack !== 1'b1 || wr_count !== 0) $display("FAIL win_ack got=%b/%0d exp=1/0", s_ack, wr_count); else passed++;
        tick();
        tick();
        total++; if ({s_grant, s_wr, s_data} !== {2'b01, 1'b1, 8'h77}) $display("FAIL win_resume got=%b/%b/%h exp=01/1/77", s_grant, s_wr, s_data); else passed++;
    endtask

    task automatic test_valid_drop();
        do_reset();
        q1.push_back(8'h3C);
        drive();
        tick();
        tick();
        total++; if ({s_grant, s_wr, s_data} !== {2'b10, 1'b1, 8'h3C}) $display("FAIL drop_write got=%b/%b/%h exp=10/1/3c", s_grant, s_wr, s_data); else passed++;
        tick();
        total++; if ({s_grant, s_wr} !== 3'b100) $display("FAIL drop_last got=%b exp=100", {s_grant, s_wr}); else passed++;
        tick();
        total++; if (s_grant !== 2'b00) $display("FAIL drop_exit got=%b exp=00", s_grant); else passed++;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        repeat (4) q0.push_back(8'($urandom));
        drive();
        tick();
        #1;
        total++; if (tx_fifo_write_o !== 1'b1) $display("FAIL rstg_pre got=%b exp=1", tx_fifo_write_o); else passed++;
        rst_i = 1'b1;
        #1;
        total++; if ({tx_fifo_write_o, ch0_ready_o, grant_o, enable_o} !== 5'b00000) $display("FAIL rstg_drop got=%b exp=00000", {tx_fifo_write_o, ch0_ready_o, grant_o, enable_o}); else passed++;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic test_reset_mid_cfg();
        logic found = 1'b0;
        do_reset();
        q0.push_back(8'h11);
        drive();
        repeat (4) tick();
        cfg_req_i = 1'b1; tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            found = s_cm;
        end
        total++; if (found !== 1'b1) $display("FAIL rstc_enter got=%b exp=1", found); else passed++;
        #2 rst_i = 1'b1;
        #1;
        total++; if ({config_req_mst_o, enable_o, cfg_ack_o} !== 3'b000) $display("FAIL rstc_drop got=%b exp=000", {config_req_mst_o, enable_o, cfg_ack_o}); else passed++;
        cfg_req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        q0.push_back(8'h21); q1.push_back(8'h22);
        drive();
        tick();
        total++; if (s_grant !== 2'b00) $display("FAIL rstc_idle got=%b exp=00", s_grant); else passed++;
        tick();
        total++; if ({s_grant, s_data} !== {2'b01, 8'h21}) $display("FAIL rstc_rr got=%b/%h exp=01/21", s_grant, s_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_burst_alternate();
        test_fifo_full();
        test_random_traffic();
        test_cfg_mid_grant();
        test_cfg_wins();
        test_valid_drop();
        test_reset_mid_grant();
        test_reset_mid_cfg();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
